// File: rtl/lc3_key_stepper.sv
// lc3_key_stepper
//
// Turns three raw board pushbuttons into clean single-cycle step pulses for
// an LC-3 processor front panel. Each key is synchronized, debounced by its
// own small state machine and counter, and produces exactly one pulse per
// accepted press no matter how long it is held.
//
// Optional feature: define LC3_AUTORUN_EN to add an autorun timer. While the
// synchronized run_en switch is high, step_pulse[0] fires once every
// RUN_PERIOD cycles, merged with the key-0 pulse. Without the macro run_en is
// ignored and run_active is tied low.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a transition
//   CNT_W            width of the debounce and autorun counters
//   RUN_PERIOD       autorun step interval in clk cycles (>= 2)
//
// Ports:
//   clk         board clock, all state updates on its rising edge
//   rst_n       asynchronous active-low reset
//   key_n[2:0]  raw pushbuttons, low = pressed (asynchronous)
//   run_en      autorun request switch (asynchronous)
//   step_pulse  one-cycle pulse per accepted press
//               bit 0 processor step, bit 1 register-read step,
//               bit 2 direct-memory step
//   key_level   debounced key state, 1 = pressed
//   run_active  autorun currently generating steps

module lc3_key_stepper #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 20,
   parameter int RUN_PERIOD      = 500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] key_n,
   input  logic       run_en,
   output logic [2:0] step_pulse,
   output logic [2:0] key_level,
   output logic       run_active
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } key_state_t;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [2:0] key_meta;
   logic [2:0] key_sync;
   logic [2:0] key_down;
   logic [2:0] press_accept;
   logic       auto_fire;

   // Two-flop synchronizer for the raw keys; resets to the released level so
   // nothing looks pressed while coming out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_meta <= 3'b111;
         key_sync <= 3'b111;
      end else begin
         key_meta <= key_n;
         key_sync <= key_meta;
      end
   end

   assign key_down = ~key_sync;

   for (genvar i = 0; i < 3; i++) begin : g_key
      key_state_t       state;
      logic [CNT_W-1:0] cnt;
      logic             level;

      // Per-key debounce FSM. The counter stops at DB_LAST, so it never wraps;
      // the transition fires on the cycle the last stable sample is seen.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (key_down[i]) begin
                     state <= PRESS_WAIT;
                     cnt   <= '0;
                  end
               end
               PRESS_WAIT: begin
                  if (!key_down[i]) begin
                     state <= IDLE;
                  end else if (cnt == DB_LAST) begin
                     state <= PRESSED;
                     level <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               PRESSED: begin
                  if (!key_down[i]) begin
                     state <= RELEASE_WAIT;
                     cnt   <= '0;
                  end
               end
               RELEASE_WAIT: begin
                  if (key_down[i]) begin
                     state <= PRESSED;
                  end else if (cnt == DB_LAST) begin
                     state <= IDLE;
                     level <= 1'b0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
                  level <= 1'b0;
               end
            endcase
         end
      end

      // Press accepted exactly when PRESS_WAIT completes; only this edge
      // pulses, so bounces during release never create a second step.
      assign press_accept[i] = (state == PRESS_WAIT) && key_down[i] && (cnt == DB_LAST);
      assign key_level[i]    = level;
   end

`ifdef LC3_AUTORUN_EN
   localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_PERIOD - 1);

   logic             run_meta;
   logic             run_sync;
   logic [CNT_W-1:0] run_cnt;

   // Run switch synchronizer plus a free-running step timer that is held at
   // zero whenever autorun is off, so the first step always comes a full
   // period after enabling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_meta <= 1'b0;
         run_sync <= 1'b0;
         run_cnt  <= '0;
      end else begin
         run_meta <= run_en;
         run_sync <= run_meta;
         if (!run_sync || (run_cnt == RUN_LAST)) begin
            run_cnt <= '0;
         end else begin
            run_cnt <= run_cnt + CNT_W'(1);
         end
      end
   end

   assign auto_fire  = run_sync && (run_cnt == RUN_LAST);
   assign run_active = run_sync;
`else
   logic unused_run;

   assign unused_run = run_en & (RUN_PERIOD > 1);
   assign auto_fire  = 1'b0;
   assign run_active = 1'b0;
`endif

   // Registered step outputs; an autorun tick coinciding with a key-0 press
   // collapses into one pulse through the OR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_pulse <= 3'b000;
      end else begin
         step_pulse <= press_accept | {2'b00, auto_fire};
      end
   end

endmodule

// File: tb/tb_lc3_key_stepper.sv
// Testbench for lc3_key_stepper with DEBOUNCE_CYCLES=4 and RUN_PERIOD=8.
// Directed table of key patterns with hand-derived pulse counts and levels,
// a few multi-cycle sequences (reset mid-press, simultaneous keys, autorun),
// and a randomized phase compared every cycle against a reference model that
// accepts a key change after it has been seen for DB+1 consecutive cycles.

module tb_lc3_key_stepper;

   localparam int DB = 4;
   localparam int RP = 8;

   logic       clk;
   logic       rst_n;
   logic [2:0] key_n;
   logic       run_en;
   logic [2:0] step_pulse;
   logic [2:0] key_level;
   logic       run_active;

   int errors = 0;
   int checks = 0;
   bit chk_en = 0;

   lc3_key_stepper #(
      .DEBOUNCE_CYCLES(DB),
      .CNT_W(8),
      .RUN_PERIOD(RP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .key_n(key_n),
      .run_en(run_en),
      .step_pulse(step_pulse),
      .key_level(key_level),
      .run_active(run_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: two-sample input delay, then a key flips its debounced
   // level once the delayed input has disagreed with it DB+1 times in a row.
   logic [2:0] m_s1, m_s2;
   logic [2:0] m_level, m_pulse;
   int         m_run [3];
   logic       m_r1, m_r2;
   int         m_since;
   logic       m_down;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 = 3'b111;
         m_s2 = 3'b111;
         m_level = 3'b000;
         m_pulse = 3'b000;
         for (int i = 0; i < 3; i++) m_run[i] = 0;
         m_r1 = 1'b0;
         m_r2 = 1'b0;
         m_since = 0;
      end else begin
         m_pulse = 3'b000;
         for (int i = 0; i < 3; i++) begin
            m_down = !m_s2[i];
            if (m_down != m_level[i]) begin
               m_run[i] = m_run[i] + 1;
               if (m_run[i] == DB + 1) begin
                  m_level[i] = m_down;
                  m_run[i] = 0;
                  if (m_down) m_pulse[i] = 1'b1;
               end
            end else begin
               m_run[i] = 0;
            end
         end
`ifdef LC3_AUTORUN_EN
         if (m_r2) begin
            m_since = m_since + 1;
            if (m_since % RP == 0) m_pulse[0] = 1'b1;
         end else begin
            m_since = 0;
         end
`endif
         m_s2 = m_s1;
         m_s1 = key_n;
         m_r2 = m_r1;
         m_r1 = run_en;
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive inputs just after a falling edge and hold them for n rising edges,
   // counting pulses per bit as seen on each following falling edge.
   task automatic applyStimulus(input logic [2:0] k, input logic r, input int n,
                                output int pc0, output int pc1, output int pc2);
      pc0 = 0;
      pc1 = 0;
      pc2 = 0;
      #1;
      key_n = k;
      run_en = r;
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (step_pulse[0]) pc0++;
         if (step_pulse[1]) pc1++;
         if (step_pulse[2]) pc2++;
      end
   endtask

   // Every-cycle comparison against the model.
   logic exp_active;
   always @(negedge clk) begin
      if (chk_en) begin
`ifdef LC3_AUTORUN_EN
         exp_active = m_r2;
`else
         exp_active = 1'b0;
`endif
         checkOutput("cyc_step_pulse", int'(step_pulse), int'(m_pulse));
         checkOutput("cyc_key_level", int'(key_level), int'(m_level));
         checkOutput("cyc_run_active", int'(run_active), int'(exp_active));
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic [2:0] key_n;
      int         cycles;
      int         p0;
      int         p1;
      int         p2;
      logic [2:0] level;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int a, b, c;
      int first, cnt;
      logic [2:0] val;
      logic act0, act1, act_any;
      int hold [3];
      int rhold;
      logic [2:0] kcur;

      vecs[0]  = '{3'b110, 20, 1, 0, 0, 3'b001};
      vecs[1]  = '{3'b111, 10, 0, 0, 0, 3'b000};
      vecs[2]  = '{3'b101,  2, 0, 0, 0, 3'b000};
      vecs[3]  = '{3'b111,  1, 0, 0, 0, 3'b000};
      vecs[4]  = '{3'b101, 20, 0, 1, 0, 3'b010};
      vecs[5]  = '{3'b111, 10, 0, 0, 0, 3'b000};
      vecs[6]  = '{3'b000, 20, 1, 1, 1, 3'b111};
      vecs[7]  = '{3'b111, 10, 0, 0, 0, 3'b000};
      vecs[8]  = '{3'b011, 20, 0, 0, 1, 3'b100};
      vecs[9]  = '{3'b111,  2, 0, 0, 0, 3'b100};
      vecs[10] = '{3'b011, 10, 0, 0, 0, 3'b100};
      vecs[11] = '{3'b111, 10, 0, 0, 0, 3'b000};

      rst_n = 1'b0;
      key_n = 3'b111;
      run_en = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_step_pulse", int'(step_pulse), 0);
      checkOutput("reset_key_level", int'(key_level), 0);
      checkOutput("reset_run_active", int'(run_active), 0);
      #1;
      rst_n = 1'b1;
      chk_en = 1'b1;
      applyStimulus(3'b111, 1'b0, 4, a, b, c);

      // Directed table: clean press, bounce, release, simultaneous, release bounce.
      for (int v = 0; v < 12; v++) begin
         applyStimulus(vecs[v].key_n, 1'b0, vecs[v].cycles, a, b, c);
         checkOutput($sformatf("vec%0d_pulses0", v), a, vecs[v].p0);
         checkOutput($sformatf("vec%0d_pulses1", v), b, vecs[v].p1);
         checkOutput($sformatf("vec%0d_pulses2", v), c, vecs[v].p2);
         checkOutput($sformatf("vec%0d_level", v), int'(key_level), int'(vecs[v].level));
      end

      // Simultaneous press: one cycle of 3'b111, six edges after the drive.
      #1;
      key_n = 3'b000;
      first = -1;
      val = 3'b000;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (step_pulse != 3'b000 && first < 0) begin
            first = i;
            val = step_pulse;
         end
      end
      checkOutput("simul_first_edge", first, DB + 2);
      checkOutput("simul_value", int'(val), 7);
      applyStimulus(3'b111, 1'b0, 12, a, b, c);

      // Reset while key 0 is in PRESS_WAIT, then re-debounce after release.
      #1;
      key_n = 3'b110;
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_step_pulse", int'(step_pulse), 0);
      checkOutput("midrst_key_level", int'(key_level), 0);
      checkOutput("midrst_run_active", int'(run_active), 0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      first = -1;
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (step_pulse[0]) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      checkOutput("midrst_first_edge", first, DB + 2);
      checkOutput("midrst_pulse_count", cnt, 1);
      applyStimulus(3'b111, 1'b0, 12, a, b, c);

      // Autorun behaviour.
      #1;
      run_en = 1'b1;
      first = -1;
      cnt = 0;
      act0 = 1'b0;
      act1 = 1'b0;
      act_any = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (i == 0) act0 = run_active;
         if (i == 1) act1 = run_active;
         if (run_active) act_any = 1'b1;
         if (step_pulse[0]) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
`ifdef LC3_AUTORUN_EN
      checkOutput("auto_active_edge0", int'(act0), 0);
      checkOutput("auto_active_edge1", int'(act1), 1);
      checkOutput("auto_first_pulse", first, 1 + RP);
      checkOutput("auto_pulse_count", cnt, 3);
      applyStimulus(3'b111, 1'b0, 20, a, b, c);
      checkOutput("auto_off_pulses", a, 0);
      checkOutput("auto_off_active", int'(run_active), 0);
      #1;
      run_en = 1'b1;
      first = -1;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (step_pulse[0] && first < 0) first = i;
      end
      checkOutput("auto_restart_first", first, 1 + RP);
      applyStimulus(3'b111, 1'b0, 20, a, b, c);
`else
      checkOutput("noauto_active_any", int'(act_any), 0);
      checkOutput("noauto_pulse_count", cnt, 0);
      applyStimulus(3'b111, 1'b0, 4, a, b, c);
`endif

      // Randomized bouncing keys and run switch, checked every cycle by the model.
      for (int i = 0; i < 3; i++) hold[i] = 0;
      rhold = 0;
      kcur = 3'b111;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         #1;
         for (int i = 0; i < 3; i++) begin
            if (hold[i] == 0) begin
               kcur[i] = 1'($urandom_range(0, 1));
               hold[i] = $urandom_range(1, 9);
            end
            hold[i]--;
         end
         if (rhold == 0) begin
            run_en = 1'($urandom_range(0, 1));
            rhold = $urandom_range(5, 40);
         end
         rhold--;
         key_n = kcur;
         if (cyc == 700) rst_n = 1'b0;
         if (cyc == 702) rst_n = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end

      applyStimulus(3'b111, 1'b0, 20, a, b, c);
      checkOutput("final_key_level", int'(key_level), 0);
      chk_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lc3_key_stepper.md
LC3_KEY_STEPPER -- requirements
Module: lc3_key_stepper

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning the number of consecutive stable clk cycles needed to accept a key transition (1 ms at 50 MHz).
REQ-002 The block SHALL have parameter CNT_W, default 20, meaning the width of each debounce counter and the autorun counter; it SHALL hold DEBOUNCE_CYCLES-1 and RUN_PERIOD-1.
REQ-003 The block SHALL have parameter RUN_PERIOD, default 500000, meaning the autorun step interval in clk cycles; it SHALL be at least 2.
REQ-004 Port clk, input, 1 bit: the single board clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port key_n, input, 3 bits: raw pushbuttons, asynchronous, low = pressed.
REQ-007 Port run_en, input, 1 bit: autorun request, asynchronous (switch).
REQ-008 Port step_pulse, output, 3 bits: one-clk-cycle pulse per accepted press; bit 0 = processor step, bit 1 = register-read step, bit 2 = direct-memory step.
REQ-009 Port key_level, output, 3 bits: debounced key state, 1 = pressed.
REQ-010 Port run_active, output, 1 bit: autorun currently generating steps.

Function
REQ-011 key_n and run_en SHALL each pass through a 2-flop synchronizer before use.
REQ-012 Each key SHALL have an independent 4-state FSM (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT) and its own counter.
- IDLE: synced key low -> PRESS_WAIT, counter=0.
- PRESS_WAIT: key low -> counter+1; key high before the count completes -> IDLE; counter==DEBOUNCE_CYCLES-1 while low -> PRESSED.
- PRESSED: key high -> RELEASE_WAIT, counter=0.
- RELEASE_WAIT: key high -> counter+1; key low before the count completes -> PRESSED with no new pulse; counter==DEBOUNCE_CYCLES-1 while high -> IDLE.
REQ-013 step_pulse[i] SHALL be registered and high for exactly the one cycle after the PRESS_WAIT->PRESSED transition; a held key SHALL produce no further pulses.
REQ-014 Latency: with key_n[i] stable low from edge 0, step_pulse[i] SHALL be high during the cycle after edge DEBOUNCE_CYCLES+2.
REQ-015 key_level[i] SHALL be 1 in the PRESSED and RELEASE_WAIT states and 0 otherwise.
REQ-016 Two or three keys accepted on the same cycle SHALL pulse on the same cycle, independently.
REQ-017 Counters SHALL never wrap; the comparison SHALL end counting at DEBOUNCE_CYCLES-1.

Reset
REQ-018 While rst_n is low:
- all FSMs SHALL be in IDLE;
- all counters SHALL be 0;
- synchronizer flops for key_n SHALL be 1 (released); synchronizer flops for run_en SHALL be 0;
- step_pulse, key_level and run_active SHALL all be 0.
REQ-019 A reset during PRESS_WAIT or PRESSED SHALL discard the press; a key still held after reset release SHALL re-debounce from IDLE and pulse once.

Configuration
REQ-020 With macro LC3_AUTORUN_EN defined:
- run_active SHALL be the synchronized run_en.
- While run_active=1, a free-running counter SHALL count 0..RUN_PERIOD-1 and wrap to 0; step_pulse[0] SHALL pulse when the counter equals RUN_PERIOD-1.
- An autorun pulse and a key-0 pulse in the same cycle SHALL give a single one-cycle pulse.
- When run_active is 0, the counter SHALL clear to 0, so the first step comes RUN_PERIOD cycles after run_active rises.
REQ-021 Without LC3_AUTORUN_EN:
- run_en SHALL be ignored, run_active SHALL be constant 0, and no autorun counter SHALL exist.

Verification (DEBOUNCE_CYCLES=4, RUN_PERIOD=8)
REQ-022 Clean press: key_n[0] low from edge 0 and held 20 cycles -> exactly one step_pulse[0] in the cycle after edge 6; key_level[0]=1 from then on.
REQ-023 Bounce: key_n[1] low 2 cycles, high 1, then low steady -> PRESS_WAIT aborts and restarts; one pulse, 6 cycles after the final low.
REQ-024 Release bounce: while PRESSED, key_n[2] high 2 cycles then low -> no second pulse and key_level[2] stays 1; then high 10 cycles -> key_level[2]=0.
REQ-025 Reset mid-press: rst_n low for 1 cycle during PRESS_WAIT with the key held -> outputs 0 at once; one pulse 6 cycles after rst_n rises.
REQ-026 Autorun (LC3_AUTORUN_EN): run_en=1 -> run_active=1 after 2 cycles; step_pulse[0] every 8 cycles; run_en=0 -> pulses stop and the counter is 0. Without the macro: no pulses, run_active=0.
REQ-027 Simultaneous keys: all three keys low on the same edge -> step_pulse=3'b111 for one cycle.
